// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the neuron accumulator.
// Holds encodings, the FSM state type and the combinational FP16 operators
// (multiply, add, ReLU). Arithmetic flushes denormal inputs and results to
// signed zero, rounds to nearest-even, saturates overflow to +/-inf and
// returns a single canonical quiet NaN for every invalid case.
package fp16_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUT} state_t;

  // Round an 11-bit significand (hidden bit at [10]) with guard/sticky and
  // pack it. Rounding happens before the range check, so a value that
  // rounds up into the normal range is kept.
  function automatic logic [15:0] fp16_pack(input logic s, input int e,
                                             input logic [10:0] man,
                                             input logic g, input logic st);
    logic [11:0] r;
    int          ee;
    ee = e;
    r  = {1'b0, man} + 12'(g & (st | man[0]));
    if (r[11]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= 31) return {s, FP16_PINF[14:0]};
    if (ee <= 0)  return {s, 15'h0000};
    return {s, ee[4:0], r[9:0]};
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s, an, bn, ai, bi, az, bz;
    logic [21:0] p;
    int          e;
    s  = a[15] ^ b[15];
    an = (&a[14:10]) &&  (|a[9:0]);
    bn = (&b[14:10]) &&  (|b[9:0]);
    ai = (&a[14:10]) && !(|a[9:0]);
    bi = (&b[14:10]) && !(|b[9:0]);
    az = ~|a[14:10];
    bz = ~|b[14:10];
    if (an || bn || (ai && bz) || (az && bi)) return FP16_QNAN;
    if (ai || bi) return {s, FP16_PINF[14:0]};
    if (az || bz) return {s, 15'h0000};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) return fp16_pack(s, e + 1, p[21:11], p[10], |p[9:0]);
    return fp16_pack(s, e, p[20:10], p[9], |p[8:0]);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic        an, bn, ai, bi, az, bz;
    logic [15:0] x, y;
    logic [49:0] t;
    logic [25:0] xa, yb, sm, nrm;
    int          d, p, e;
    an = (&a[14:10]) &&  (|a[9:0]);
    bn = (&b[14:10]) &&  (|b[9:0]);
    ai = (&a[14:10]) && !(|a[9:0]);
    bi = (&b[14:10]) && !(|b[9:0]);
    az = ~|a[14:10];
    bz = ~|b[14:10];
    if (an || bn) return FP16_QNAN;
    if (ai && bi && (a[15] != b[15])) return FP16_QNAN;
    if (ai) return a;
    if (bi) return b;
    if (az && bz) return {a[15] & b[15], 15'h0000};
    if (az) return b;
    if (bz) return a;
    // x carries the larger magnitude so the effective subtraction is >= 0
    if (a[14:0] >= b[14:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = int'(x[14:10]) - int'(y[14:10]);
    // 13 spare bits below the significand keep guard bits exact after a
    // one-bit renormalisation; everything shifted further collapses into a
    // sticky LSB, which also biases the subtraction in the right direction.
    t  = {1'b0, 1'b1, y[9:0], 13'h0000, 25'h0000000} >> d;
    xa = {1'b0, 1'b1, x[9:0], 13'h0000, 1'b0};
    yb = {t[49:25], |t[24:0]};
    sm = (x[15] == y[15]) ? xa + yb : xa - yb;
    if (sm == 26'h0) return {x[15] & y[15], 15'h0000};
    p = 0;
    for (int i = 0; i < 26; i++) if (sm[i]) p = i;
    nrm = sm << (25 - p);
    e   = int'(x[14:10]) + p - 24;
    return fp16_pack(x[15], e, nrm[25:15], nrm[14], |nrm[13:0]);
  endfunction

  // Any value with the sign bit set (including -0 and -NaN) clamps to +0.
  function automatic logic [15:0] fp16_relu(input logic en, input logic [15:0] v);
    return (en && v[15]) ? FP16_ZERO : v;
  endfunction

endpackage

// File: rtl/fp16_dot_tree.sv
// Combinational LANES-wide FP16 dot product.
// Ports: in_data / w_data - LANES packed FP16 values, lane k at [16k+15:16k]
//        sum              - balanced-tree sum of the LANES products
// Node i of the heap-ordered tree adds nodes 2i and 2i+1, so adjacent lane
// pairs are combined first; the fixed order keeps results bit-reproducible.
module fp16_dot_tree
  import fp16_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [FP16_W*LANES-1:0] in_data,
  input  logic [FP16_W*LANES-1:0] w_data,
  output logic [FP16_W-1:0]       sum
);

  logic [FP16_W-1:0] node [1:2*LANES-1];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign node[LANES+k] = fp16_mul(in_data[FP16_W*k +: FP16_W], w_data[FP16_W*k +: FP16_W]);
  end

  for (genvar i = 1; i < LANES; i++) begin : g_node
    assign node[i] = fp16_add(node[2*i], node[2*i+1]);
  end

  assign sum = node[1];

endmodule

// File: rtl/fp16_neuron_acc.sv
// Sequential FP16 neuron: acc = bias + sum over beats of dot(in, w), then
// optional ReLU, presented on a valid/ready output.
// Ports: clk/reset    - clock, synchronous active-high reset
//        start/len/bias/relu_en - job launch, sampled only in IDLE
//        in_valid/in_ready/in_data/w_data - LANES pairs per beat
//        out_valid/out_ready/out_data     - one FP16 result per job
//        busy         - high whenever not IDLE
// Each accepted beat's tree sum lands in psum_q and is folded into acc on
// the next cycle, so the accumulator adder never sits behind the tree.
module fp16_neuron_acc
  import fp16_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int LEN_W        = 6,
  parameter bit RELU_DEFAULT = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [15:0]             bias,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FP16_W*LANES-1:0] in_data,
  input  logic [FP16_W*LANES-1:0] w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic                    busy
);

  state_t           state, state_nx;
  logic [LEN_W-1:0] len_q, cnt;
  logic             relu_q, psum_v, accept, last_beat;
  logic [15:0]      acc, psum_q, tree_sum, fold_sum, flush_acc;

  fp16_dot_tree #(.LANES(LANES)) u_tree (
    .in_data (in_data),
    .w_data  (w_data),
    .sum     (tree_sum)
  );

  assign fold_sum  = fp16_add(acc, psum_q);
  assign flush_acc = psum_v ? fold_sum : acc;
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && ((cnt + LEN_W'(1)) == len_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? OUT : ACCUM;
      ACCUM:   if (last_beat) state_nx = FLUSH;
      FLUSH:   state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      cnt      <= '0;
      relu_q   <= RELU_DEFAULT;
      acc      <= FP16_ZERO;
      psum_q   <= FP16_ZERO;
      psum_v   <= 1'b0;
      out_data <= FP16_ZERO;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_q  <= len;
          relu_q <= relu_en;
          acc    <= bias;
          cnt    <= '0;
          psum_v <= 1'b0;
          if (len == '0) out_data <= fp16_relu(relu_en, bias);
        end
        ACCUM: begin
          if (psum_v) acc <= fold_sum;
          psum_v <= accept;
          if (accept) begin
            psum_q <= tree_sum;
            cnt    <= cnt + LEN_W'(1);
          end
        end
        FLUSH: begin
          acc      <= flush_acc;
          out_data <= fp16_relu(relu_q, flush_acc);
          psum_v   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_neuron_acc.sv
module tb_fp16_neuron_acc;
  localparam int LANES = 4;
  localparam int LEN_W = 6;
  localparam int DW    = 16 * LANES;

  logic             clk = 1'b0;
  logic             reset, start, relu_en, in_valid, out_ready;
  logic [LEN_W-1:0] len;
  logic [15:0]      bias;
  logic [DW-1:0]    in_data, w_data;
  logic             in_ready, out_valid, busy;
  logic [15:0]      out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp16_neuron_acc #(.LANES(LANES), .LEN_W(LEN_W), .RELU_DEFAULT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .bias(bias),
    .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (real arithmetic + explicit rounding) ----
  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_nan(input logic [15:0] h);  return (h[14:10] == 5'd31) && (h[9:0] != 10'd0); endfunction
  function automatic bit is_inf(input logic [15:0] h);  return (h[14:10] == 5'd31) && (h[9:0] == 10'd0); endfunction
  function automatic bit is_zero(input logic [15:0] h); return h[14:10] == 5'd0; endfunction

  function automatic real f2r(input logic [15:0] h);
    real m;
    if (is_zero(h)) return 0.0;
    m = real'(1024 + int'(h[9:0])) * p2(int'(h[14:10]) - 25);
    return h[15] ? -m : m;
  endfunction

  // Round a positive magnitude to 11 significant bits (nearest-even), then
  // saturate / flush according to the resulting exponent.
  function automatic logic [15:0] r2f(input logic s, input real mag);
    int  e, be, mi;
    real sc, fl, fr;
    logic [15:0] r;
    if (mag == 0.0) return {s, 15'h0};
    e = 0;
    while (mag >= p2(e + 1)) e++;
    while (mag < p2(e)) e--;
    sc = mag / p2(e - 10);
    fl = $floor(sc);
    fr = sc - fl;
    if (fr > 0.5 || (fr == 0.5 && (int'(fl) % 2) == 1)) fl = fl + 1.0;
    if (fl >= 2048.0) begin fl = 1024.0; e++; end
    be = e + 15;
    if (be >= 31) return {s, 15'h7C00};
    if (be <= 0)  return {s, 15'h0};
    mi = int'(fl) - 1024;
    r = {s, be[4:0], mi[9:0]};
    return r;
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    logic s = a[15] ^ b[15];
    real v;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) return 16'h7E00;
    if (is_inf(a) || is_inf(b)) return {s, 15'h7C00};
    if (is_zero(a) || is_zero(b)) return {s, 15'h0};
    v = f2r(a) * f2r(b);
    return r2f(s, v < 0.0 ? -v : v);
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    real v;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (is_inf(a) && is_inf(b) && (a[15] != b[15])) return 16'h7E00;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    v = f2r(a) + f2r(b);
    if (v == 0.0) return {a[15] & b[15], 15'h0};
    return r2f(v < 0.0, v < 0.0 ? -v : v);
  endfunction

  function automatic logic [15:0] m_beat(input logic [DW-1:0] di, input logic [DW-1:0] wi);
    logic [15:0] v[$];
    logic [15:0] nv[$];
    for (int k = 0; k < LANES; k++) v.push_back(m_mul(di[16*k +: 16], wi[16*k +: 16]));
    while (v.size() > 1) begin
      nv.delete();
      for (int i = 0; i < v.size(); i += 2) nv.push_back(m_add(v[i], v[i+1]));
      v = nv;
    end
    return v[0];
  endfunction

  function automatic logic [15:0] m_neuron(input int l, input logic [15:0] b, input logic r,
                                           input logic [DW-1:0] di [8], input logic [DW-1:0] wi [8]);
    logic [15:0] a = b;
    for (int i = 0; i < l; i++) a = m_add(a, m_beat(di[i], wi[i]));
    return (r && a[15]) ? 16'h0000 : a;
  endfunction

  function automatic logic [15:0] rand_fp();
    if ($urandom_range(0, 99) < 4) begin
      case ($urandom_range(0, 7))
        0: return 16'h0000; 1: return 16'h8000; 2: return 16'h7C00; 3: return 16'hFC00;
        4: return 16'h7E00; 5: return 16'h0001; 6: return 16'h0400; default: return 16'h7BFF;
      endcase
    end
    return {1'($urandom_range(0, 1)), 5'($urandom_range(6, 22)), 10'($urandom)};
  endfunction

  // ---------------- one complete job through the handshakes ------------------
  task automatic run(input logic [LEN_W-1:0] l, input logic [15:0] b, input logic r,
                     input logic [DW-1:0] din [8], input logic [DW-1:0] wdin [8],
                     input int vprob, input int hold, input string name,
                     output logic [15:0] res, output int lat);
    int idx, cyc;
    bit saw_rdy, acc_b;
    start = 1'b1; len = l; bias = b; relu_en = r;
    tick();
    start = 1'b0;
    idx = 0; cyc = 0; saw_rdy = 1'b0;
    while (idx < int'(l) && cyc < 400) begin
      in_valid = ($urandom_range(0, 99) < vprob);
      in_data  = din[idx];
      w_data   = wdin[idx];
      saw_rdy |= in_ready;
      acc_b    = in_valid && in_ready;
      tick();
      cyc++;
      if (acc_b) idx++;
    end
    in_valid = 1'b0;
    chk({name, " beats"}, idx, int'(l));
    lat = 1; cyc = 0;
    while (!out_valid && cyc < 20) begin
      saw_rdy |= in_ready;
      tick();
      lat++; cyc++;
    end
    chk({name, " out_valid"}, out_valid, 1);
    if (l == '0) chk({name, " no in_ready"}, saw_rdy, 0);
    res = out_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({name, " hold"}, {out_valid, out_data}, {1'b1, res});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, " post idle"}, {out_valid, busy}, 2'b00);
  endtask

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [15:0]      bias;
    logic             relu;
    logic [DW-1:0]    din;
    logic [DW-1:0]    wdin;
    logic [15:0]      exp;
  } vec_t;

  vec_t          tbl [15];
  logic [DW-1:0] din  [8];
  logic [DW-1:0] wdin [8];
  logic [15:0]   res, hold0;
  int            lat, n, cyc;
  logic [4:0]    pat;

  initial begin
    tbl[0]  = '{6'd1, 16'h0000, 1'b0, 64'hBC00_3800_4000_3C00, {4{16'h4000}}, 16'h4500};
    tbl[1]  = '{6'd1, 16'hC000, 1'b1, {4{16'h3C00}}, {4{16'hBC00}}, 16'h0000};
    tbl[2]  = '{6'd1, 16'hC000, 1'b0, {4{16'h3C00}}, {4{16'hBC00}}, 16'hC600};
    tbl[3]  = '{6'd0, 16'h4200, 1'b1, '0, '0, 16'h4200};
    tbl[4]  = '{6'd0, 16'h8000, 1'b1, '0, '0, 16'h0000};
    tbl[5]  = '{6'd0, 16'h8000, 1'b0, '0, '0, 16'h8000};
    tbl[6]  = '{6'd1, 16'h0000, 1'b1, 64'h0000_0000_0000_7E00, {4{16'h3C00}}, 16'h7E00};
    tbl[7]  = '{6'd1, 16'h0000, 1'b0, 64'h0000_0000_0000_7BFF, {4{16'h4000}}, 16'h7C00};
    tbl[8]  = '{6'd1, 16'h0000, 1'b0, 64'h0000_0000_FC00_7C00, {4{16'h3C00}}, 16'h7E00};
    tbl[9]  = '{6'd1, 16'h3C00, 1'b0, 64'h0000_0000_0000_0001, {4{16'h7BFF}}, 16'h3C00};
    tbl[10] = '{6'd1, 16'h0000, 1'b0, 64'h0000_0000_0000_0400, {4{16'h3800}}, 16'h0000};
    tbl[11] = '{6'd1, 16'h3C00, 1'b0, 64'h0000_0000_0000_1000, {4{16'h3C00}}, 16'h3C00};
    tbl[12] = '{6'd1, 16'h3C01, 1'b0, 64'h0000_0000_0000_1000, {4{16'h3C00}}, 16'h3C02};
    tbl[13] = '{6'd0, 16'hFE00, 1'b1, '0, '0, 16'h0000};
    tbl[14] = '{6'd2, 16'h0000, 1'b0, {4{16'h4000}}, {4{16'h4000}}, 16'h5000};

    reset = 1'b1; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; w_data = '0;
    tick(); tick(); tick();
    chk("reset state", {in_ready, out_valid, busy, out_data}, 19'h0);
    reset = 1'b0;
    tick();

    // directed vectors
    foreach (tbl[t]) begin
      for (int i = 0; i < 8; i++) begin din[i] = tbl[t].din; wdin[i] = tbl[t].wdin; end
      run(tbl[t].len, tbl[t].bias, tbl[t].relu, din, wdin, 100, 1, $sformatf("vec%0d", t), res, lat);
      chk($sformatf("vec%0d result", t), res, tbl[t].exp);
      chk($sformatf("vec%0d latency", t), lat, (tbl[t].len == '0) ? 1 : 2);
    end

    // in_valid toggled 1,0,1,0,1 across a 3-beat job
    start = 1'b1; len = 6'd3; bias = 16'h3C00; relu_en = 1'b0;
    tick();
    start = 1'b0;
    n = 0; pat = 5'b10101;
    for (int c = 0; c < 5; c++) begin
      in_valid = pat[c]; in_data = {4{16'h3C00}}; w_data = {4{16'h3800}};
      if (in_valid && in_ready) n++;
      tick();
    end
    in_valid = 1'b0;
    chk("toggle beats", n, 3);
    chk("toggle ready drop", {in_ready, busy}, 2'b01);
    tick();
    chk("toggle result", {out_valid, out_data}, {1'b1, 16'h4700});
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // output backpressure with start pulsed during OUT
    start = 1'b1; len = 6'd1; bias = 16'h0000; relu_en = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = tbl[0].din; w_data = tbl[0].wdin;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    hold0 = out_data;
    chk("bp first", {out_valid, hold0}, {1'b1, 16'h4500});
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; len = 6'd0; bias = 16'h4400; out_ready = 1'b0;
      tick();
      chk("bp hold", {out_valid, busy, out_data}, {2'b11, 16'h4500});
    end
    out_ready = 1'b1;   // start still high: must be ignored on the handshake cycle
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("bp release", {out_valid, busy}, 2'b00);
    start = 1'b1; len = 6'd0; bias = 16'h4400; relu_en = 1'b0;
    tick();
    start = 1'b0;
    chk("bp next start", {out_valid, out_data}, {1'b1, 16'h4400});
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // reset in the middle of accumulation
    start = 1'b1; len = 6'd4; bias = 16'h4000; relu_en = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = {4{16'h4000}}; w_data = {4{16'h4000}};
    tick(); tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset", {in_ready, out_valid, busy, out_data}, 19'h0);
    for (int i = 0; i < 8; i++) begin din[i] = tbl[0].din; wdin[i] = tbl[0].wdin; end
    run(6'd1, 16'h0000, 1'b0, din, wdin, 100, 0, "after reset", res, lat);
    chk("after reset result", res, 16'h4500);

    // randomized jobs against the model
    for (int j = 0; j < 40; j++) begin
      logic [LEN_W-1:0] l;
      logic [15:0]      b, e;
      logic             r;
      l = LEN_W'($urandom_range(0, 5));
      b = rand_fp();
      r = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < LANES; k++) begin
          din[i][16*k +: 16]  = rand_fp();
          wdin[i][16*k +: 16] = rand_fp();
        end
      e = m_neuron(int'(l), b, r, din, wdin);
      run(l, b, r, din, wdin, 70, $urandom_range(0, 3), $sformatf("rnd%0d", j), res, lat);
      chk($sformatf("rnd%0d result", j), res, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
